fetch_decode_queue: RTL
=======================

Name: fetch_decode_queue

Overview:
- Sits between the instruction fetch stage (PC/NPC plus instruction memory read) and the decode stage.
- Buffers fetched {pc, pc4, instruction} entries in a small circular FIFO with valid/ready handshakes on both sides.
- Decouples the fetch stage from decode back-pressure, such as the load-use stall.
- Discards all buffered entries on a control-flow redirect (flush).

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- AW, 2, pointer width, equal to log2(DEPTH).
- XLEN, 32, width of pc, pc4 and instruction fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  fetch presents an entry this cycle.
- in_pc  input  XLEN  address of the fetched instruction.
- in_pc4  input  XLEN  in_pc + 4, as produced by fetch.
- in_instr  input  XLEN  fetched instruction word.
- in_ready  output  1  queue can accept an entry this cycle.
- flush  input  1  redirect taken (npc_op asserted with a new target); discard all entries.
- out_valid  output  1  head entry valid toward decode.
- out_pc  output  XLEN  head entry pc.
- out_pc4  output  XLEN  head entry pc4.
- out_instr  output  XLEN  head entry instruction.
- out_ready  input  1  decode accepts the head entry (driven as ~load_use_stall_flag).
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0.
  - All storage entries cleared to 0, so out_pc/out_pc4/out_instr read 0.
  - in_ready=1 once rst deasserts.
- Handshakes:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It does not depend on out_ready, which avoids a combinational path from decode to fetch.
  - out_valid = (count != 0) & ~flush.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 (registered storage, head read combinationally from the rd_ptr entry).
- Push: write {in_pc, in_pc4, in_instr} to the wr_ptr entry; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH (natural AW-bit overflow).
- Pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. This is legal whenever 0<count<DEPTH.
  - When full, push is impossible (in_ready=0); pop alone is allowed.
  - When empty, pop is impossible (out_valid=0); push alone is allowed.
- Flush (synchronous, highest priority):
  - At the next edge, wr_ptr=rd_ptr=0 and count=0.
  - Any same-cycle push is dropped.
  - out_valid=0 during the flush cycle, so decode never consumes a wrong-path entry.
  - Storage contents are not cleared.
- Flush with in_valid in the following cycle: the new-target entry is accepted normally (in_ready=1).
- Out-of-range values:
  - out_pc, out_pc4 and out_instr are don't-care while out_valid=0 (after reset they read 0).
  - No arithmetic is performed on pc fields; they are stored verbatim.
- Stability: while out_valid=1 and out_ready=0, the head outputs hold stable until popped or flushed.
- Reset asserted mid-operation: immediate return to the reset state; buffered entries are lost.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0 and in_valid=1 and flush=0, out_valid=1 and the outputs are driven combinationally from in_* (zero latency).
  - If out_ready=1 in that cycle, the entry is consumed directly: no write, pointers and count unchanged.
  - If out_ready=0, the entry is written normally (count becomes 1).
- Undefined:
  - Strict 1-cycle latency as above, with no combinational path from in_* to out_*.

Test Plan:
- Reset, then idle:
  - rst=0 for 2 cycles then 1 -> out_valid=0, count=0, in_ready=1, out_pc=0.
- Streaming:
  - out_ready=1, push pc=0x0,0x4,0x8 (instr 0x00000013) on consecutive cycles -> out_pc 0x0,0x4,0x8 one cycle later each, in order.
  - count stays 1 throughout.
  - out_pc4 equals pc+4.
- Fill and back-pressure:
  - out_ready=0, push 5 entries pc=0x100..0x110 -> count reaches 4, in_ready=0 after the 4th push, 5th not accepted.
  - Head holds 0x100.
  - Then out_ready=1 -> pops 0x100,0x104,0x108,0x10C in order, in_ready=1 after the first pop.
- Wrap-around:
  - 10 pushes with alternating 1-cycle stalls -> pointers wrap past 3.
  - No loss or duplication; output sequence equals input sequence.
- Flush:
  - With 3 entries queued, assert flush together with in_valid (pc=0x200) -> out_valid=0 that cycle, count=0 next cycle, 0x200 dropped.
  - Next push of pc=0x300 appears at out_pc one cycle later.
- Async reset mid-stream:
  - Drop rst between clock edges with count=2 -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
  - With FETCH_QUEUE_BYPASS_EN defined: when empty, a push of pc=0x40 shows out_valid=1, out_pc=0x40 in the same cycle.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Small circular FIFO between instruction fetch and decode. Each entry
//   holds {pc, pc4, instruction}. Fetch pushes with a valid/ready handshake,
//   and decode pops the head with its own valid/ready handshake. A flush
//   (control-flow redirect) discards every buffered entry at the next edge.
//
//   Optional feature macro: FETCH_QUEUE_BYPASS_EN
//     When defined and the queue is empty, an incoming entry is presented to
//     decode in the same cycle. If decode accepts it, the entry is never
//     written. When undefined, latency is exactly one cycle and there is no
//     combinational path from in_* to out_*.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   fetch presents an entry
//   in_pc      pc of fetched instruction
//   in_pc4     pc + 4 as produced by fetch
//   in_instr   fetched instruction word
//   in_ready   queue can accept an entry (not full)
//   flush      redirect: discard all entries
//   out_valid  head entry valid toward decode
//   out_pc     head pc
//   out_pc4    head pc4
//   out_instr  head instruction
//   out_ready  decode accepts the head entry
//   count      occupancy, 0..DEPTH
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready,
  output logic [AW:0]     count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic nonempty;
  logic push;
  logic pop;

  assign nonempty = (count_reg != '0);
  // Full-only ready: keeps decode's stall off the fetch-side timing path.
  assign in_ready = (count_reg != FULL);
  // Storage pop; with bypass active the queue is empty so this stays low.
  assign pop      = nonempty & ~flush & out_ready;
  assign count    = count_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = ~nonempty & in_valid & ~flush;
  assign out_valid = (nonempty & ~flush) | bypass;
  assign out_pc    = bypass ? in_pc    : pc_mem[rd_ptr_reg];
  assign out_pc4   = bypass ? in_pc4   : pc4_mem[rd_ptr_reg];
  assign out_instr = bypass ? in_instr : instr_mem[rd_ptr_reg];
  // A bypassed entry that decode takes immediately is never stored.
  assign push      = in_valid & in_ready & ~flush & ~(bypass & out_ready);
`else
  assign out_valid = nonempty & ~flush;
  assign out_pc    = pc_mem[rd_ptr_reg];
  assign out_pc4   = pc4_mem[rd_ptr_reg];
  assign out_instr = instr_mem[rd_ptr_reg];
  assign push      = in_valid & in_ready & ~flush;
`endif

  // Entry storage. Cleared on reset so the head reads 0 afterwards; a flush
  // only moves the pointers and leaves the contents alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        pc4_mem[i]   <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_reg]    <= in_pc;
      pc4_mem[wr_ptr_reg]   <= in_pc4;
      instr_mem[wr_ptr_reg] <= in_instr;
    end
  end

  // Pointers wrap by natural AW-bit overflow; flush has top priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule
